// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and line-level constants for the UART transmit/receive blocks.
//   tx_state_t : transmitter frame states (PARITY only entered when the
//                UART_TX_PARITY_EN build macro is defined)
//   START_BIT, STOP_BIT, IDLE_LEVEL : serial line levels
// -----------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage : uart_pkg

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer shared by the UART TX and RX paths. Counts
// 0..CLKS_PER_BIT-1 and wraps; bit_end strobes for one cycle on the last count.
// Ports:
//   clk     : system clock, posedge
//   rst     : synchronous active-high reset (count -> 0)
//   restart : clears the count so the next cycle is the first of a bit period
//   bit_end : high on the final cycle of each bit period
// -----------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic bit_end
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // Bit-period counter: cleared by reset/restart, wraps after the last count.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      count <= '0;
    end else if (count == LAST_COUNT) begin
      count <= '0;
    end else begin
      count <= count + ONE;
    end
  end

  assign bit_end = (count == LAST_COUNT);

endmodule : uart_baud_gen

// File: rtl/uart_tx_fifo_drain.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_drain
// 8N1 UART transmitter that drains a show-ahead FIFO. A byte is popped and
// captured in the same cycle, its start bit appears on tx the next cycle, and
// a waiting byte is popped on the final stop-bit cycle so frames run
// back-to-back with no idle gap.
//
// Build option: define UART_TX_PARITY_EN to insert a parity bit between the
// data bits and the stop bit (sense chosen by PARITY_ODD). Without it the
// frame is start + WIDTH data + stop and PARITY_ODD has no effect.
//
// Ports:
//   clk            : system clock, posedge
//   rst            : synchronous active-high reset; aborts any frame in flight
//   fifo_empty     : FIFO empty flag
//   fifo_read_data : FIFO head word, valid while fifo_empty is low
//   fifo_pop       : one-cycle pop strobe (combinational)
//   tx             : registered serial output, idles high
//   busy           : high while a frame is on the line
// -----------------------------------------------------------------------------
module uart_tx_fifo_drain
  import uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 434,
  parameter int PARITY_ODD   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_read_data,
  output logic             fifo_pop,
  output logic             tx,
  output logic             busy
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic PARITY_SENSE = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  tx_state_t        state;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] next_shift;
  logic [BIT_W-1:0] bit_cnt;
  logic             parity_bit;
  logic             bit_end;
  logic             baud_restart;
  logic             pop;

  // Parity over the whole captured byte, inverted for odd sense.
  function automatic logic frame_parity(input logic [WIDTH-1:0] data);
    return (^data) ^ PARITY_SENSE;
  endfunction

  // Counter held at zero while idle so START always gets a full bit period;
  // every later state entry coincides with the counter wrapping to zero.
  assign baud_restart = (state == IDLE);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .restart (baud_restart),
    .bit_end (bit_end)
  );

  assign next_shift = {1'b0, shift[WIDTH-1:1]};

  // Pop decision: only when idle or on the last stop-bit cycle, never in reset.
  always_comb begin
    pop = 1'b0;
    if (!rst && !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_end))) begin
      pop = 1'b1;
    end else begin
      pop = 1'b0;
    end
  end

  assign fifo_pop = pop;

  // Frame sequencer with registered tx/busy; a pop loads the byte and drives
  // the start bit on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= IDLE_LEVEL;
      busy       <= 1'b0;
      shift      <= '0;
      bit_cnt    <= '0;
      parity_bit <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            state      <= START;
            tx         <= START_BIT;
            busy       <= 1'b1;
            shift      <= fifo_read_data;
            parity_bit <= frame_parity(fifo_read_data);
          end else begin
            tx   <= IDLE_LEVEL;
            busy <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shift[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= STOP_BIT;
`endif
            end else begin
              shift   <= next_shift;
              tx      <= next_shift[0];
              bit_cnt <= bit_cnt + BIT_ONE;
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state <= STOP;
            tx    <= STOP_BIT;
          end else begin
            tx <= parity_bit;
          end
        end
        STOP: begin
          if (bit_end) begin
            if (pop) begin
              // Zero-gap chaining: next start bit follows the stop bit directly.
              state      <= START;
              tx         <= START_BIT;
              busy       <= 1'b1;
              shift      <= fifo_read_data;
              parity_bit <= frame_parity(fifo_read_data);
            end else begin
              state <= IDLE;
              tx    <= IDLE_LEVEL;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= IDLE_LEVEL;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : uart_tx_fifo_drain
